// File: rtl/lc3b_types.sv
// Shared LC-3b types and constants used by the memory-side blocks.
// Latency: n/a (types only).
// Backpressure: n/a.
package lc3b_types;

  localparam int LC3B_MAX_ARB_PORTS = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Index width for an N-entry selector; a single port still needs one bit.
  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin / fixed-priority picker over a request vector.
// Latency: zero cycles, purely combinational.
// Backpressure: none; winner is only meaningful while any_req is high.
module rr_picker
  import lc3b_types::*;
#(
  parameter int N_PORTS    = 2,
  parameter bit FIXED_PRIO = 1'b0,
  localparam int IDX_W     = arb_idx_w(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  // Port index reached 'off' steps above the search base, wrapping at N_PORTS.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p, input int off);
    int s;
    s = (FIXED_PRIO ? 0 : int'(p)) + off;
    if (s >= N_PORTS) s = s - N_PORTS;
    return s[IDX_W-1:0];
  endfunction

  // Scan farthest-first so the nearest set request is the last assignment.
  always_comb begin
    winner  = '0;
    any_req = |req;
    for (int off = N_PORTS - 1; off >= 0; off--) begin
      if (req[wrap_idx(ptr, off)]) winner = wrap_idx(ptr, off);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-port memory arbiter: latches one winning request and replays it downstream.
// Latency: request to dn_* one cycle; dn_resp to up_resp zero cycles.
// Backpressure: losers wait with requests held; one IDLE cycle follows every transaction.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int N_PORTS    = 2,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter bit FIXED_PRIO = 1'b0,
  localparam int IDX_W     = arb_idx_w(N_PORTS),
  localparam int BE_W      = DATA_W / 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_PORTS-1:0]        up_read,
  input  logic [N_PORTS-1:0]        up_write,
  input  logic [N_PORTS*ADDR_W-1:0] up_address,
  input  logic [N_PORTS*DATA_W-1:0] up_wdata,
  input  logic [N_PORTS*BE_W-1:0]   up_byte_enable,
  output logic [DATA_W-1:0]         up_rdata,
  output logic [N_PORTS-1:0]        up_resp,
  output logic                      dn_read,
  output logic                      dn_write,
  output logic [ADDR_W-1:0]         dn_address,
  output logic [DATA_W-1:0]         dn_wdata,
  output logic [BE_W-1:0]           dn_byte_enable,
  input  logic [DATA_W-1:0]         dn_rdata,
  input  logic                      dn_resp,
  output logic [IDX_W-1:0]          grant,
  output logic                      busy
);

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } txn_t;

  arb_state_t        state_q, state_nxt;
  txn_t              cur_q, pick;
  logic [IDX_W-1:0]  grant_q, ptr_q, ptr_nxt, winner;
  logic [N_PORTS-1:0] req;
  logic              any_req, load, done;

  assign req = up_read | up_write;

  rr_picker #(
    .N_PORTS    (N_PORTS),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_picker (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Write dominates a simultaneous read on the same port.
  always_comb begin
    pick.wr    = up_write[winner];
    pick.rd    = up_read[winner] & ~up_write[winner];
    pick.addr  = up_address[int'(winner)*ADDR_W +: ADDR_W];
    pick.wdata = up_wdata[int'(winner)*DATA_W +: DATA_W];
    pick.be    = up_byte_enable[int'(winner)*BE_W +: BE_W];
  end

  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    done      = 1'b0;
    up_resp   = '0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          load      = 1'b1;
          state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (dn_resp) begin
          done             = 1'b1;
          up_resp[grant_q] = 1'b1;
          state_nxt        = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign ptr_nxt = (int'(grant_q) == N_PORTS - 1) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      cur_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_nxt;
      if (load) begin
        cur_q   <= pick;
        grant_q <= winner;
      end
      if (done && !FIXED_PRIO) ptr_q <= ptr_nxt;
    end
  end

  // Strobes are qualified by state so the latched op never leaks into IDLE.
  assign dn_read        = (state_q == ARB_BUSY) & cur_q.rd;
  assign dn_write       = (state_q == ARB_BUSY) & cur_q.wr;
  assign dn_address     = cur_q.addr;
  assign dn_wdata       = cur_q.wdata;
  assign dn_byte_enable = cur_q.be;
  assign up_rdata       = dn_rdata;
  assign grant          = grant_q;
  assign busy           = (state_q == ARB_BUSY);

endmodule
